// File: rtl/intersection_phase_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | intersection_phase_scheduler: 4-road green/yellow/all-red sequencer with  |
// | preempt > jam > req round-robin arbitration.        Revision: 1.0         |
// +--------------------------------------------------------------------------+
module intersection_phase_scheduler #(
    parameter int GREEN_CYC     = 16,
    parameter int JAM_GREEN_CYC = 32,
    parameter int YELLOW_CYC    = 4,
    parameter int ALLRED_CYC    = 2,
    parameter int CNT_W         = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] jam,
    input  logic       preempt_valid,
    input  logic [1:0] preempt_road,
    output logic       preempt_ack,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [1:0] cur_road,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_ALLRED = 2'd3
    } phase_t;

    localparam logic [CNT_W-1:0] c_green_ld  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] c_jam_ld    = CNT_W'(JAM_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] c_yellow_ld = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] c_allred_ld = CNT_W'(ALLRED_CYC - 1);

    phase_t           phase_q, phase_d;
    logic [1:0]       cur_road_q, cur_road_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             jam_grant_q, jam_grant_d;
    logic             ack_q, ack_d;
    logic [3:0]       green_q, green_d;
    logic [3:0]       yellow_q, yellow_d;

    logic             win_valid;
    logic [1:0]       win_road;
    logic             win_pre;
    logic             jam_found, req_found;
    logic [1:0]       jam_road, req_road;
    logic [1:0]       idx;
    logic             competitor;
    logic             do_grant;
    logic [CNT_W-1:0] green_len;

    // Round-robin scan starts one past the last granted road.
    always_comb begin
        jam_found = 1'b0;
        jam_road  = 2'd0;
        req_found = 1'b0;
        req_road  = 2'd0;
        idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!jam_found && req[idx] && jam[idx]) begin
                jam_found = 1'b1;
                jam_road  = idx;
            end
            if (!req_found && req[idx]) begin
                req_found = 1'b1;
                req_road  = idx;
            end
        end

        win_valid = 1'b0;
        win_road  = 2'd0;
        win_pre   = 1'b0;
        if (preempt_valid) begin
            win_valid = 1'b1;
            win_road  = preempt_road;
            win_pre   = 1'b1;
        end else if (jam_found) begin
            win_valid = 1'b1;
            win_road  = jam_road;
        end else if (req_found) begin
            win_valid = 1'b1;
            win_road  = req_road;
        end
    end

    always_comb begin
        competitor = ((req & ~(4'b0001 << cur_road_q)) != 4'b0000) ||
                     (preempt_valid && (preempt_road != cur_road_q));
        green_len  = jam_grant_q ? c_jam_ld : c_green_ld;

        phase_d     = phase_q;
        cur_road_d  = cur_road_q;
        rr_ptr_d    = rr_ptr_q;
        timer_d     = timer_q;
        jam_grant_d = jam_grant_q;
        ack_d       = 1'b0;
        do_grant    = 1'b0;

        case (phase_q)
            PH_IDLE: begin
                do_grant = win_valid;
            end
            PH_GREEN: begin
                if (preempt_valid && (preempt_road != cur_road_q)) begin
                    phase_d = PH_YELLOW;
                    timer_d = c_yellow_ld;
                end else if (preempt_valid) begin
                    ack_d   = 1'b1;
                    timer_d = green_len;
                end else if (timer_q == '0) begin
                    if (competitor || !req[cur_road_q]) begin
                        phase_d = PH_YELLOW;
                        timer_d = c_yellow_ld;
                    end else begin
                        timer_d = green_len;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            PH_YELLOW: begin
                if (timer_q == '0) begin
                    phase_d = PH_ALLRED;
                    timer_d = c_allred_ld;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            PH_ALLRED: begin
                if (timer_q == '0) begin
                    if (win_valid) begin
                        do_grant = 1'b1;
                    end else begin
                        phase_d = PH_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: phase_d = PH_IDLE;
        endcase

        // The jam bit sampled at grant fixes the green length for every extension.
        if (do_grant) begin
            phase_d     = PH_GREEN;
            cur_road_d  = win_road;
            rr_ptr_d    = win_road;
            jam_grant_d = jam[win_road];
            timer_d     = jam[win_road] ? c_jam_ld : c_green_ld;
            ack_d       = win_pre;
        end

        green_d  = (phase_d == PH_GREEN)  ? (4'b0001 << cur_road_d) : 4'b0000;
        yellow_d = (phase_d == PH_YELLOW) ? (4'b0001 << cur_road_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_IDLE;
            cur_road_q  <= 2'd0;
            rr_ptr_q    <= 2'd3;
            timer_q     <= '0;
            jam_grant_q <= 1'b0;
            ack_q       <= 1'b0;
            green_q     <= 4'b0000;
            yellow_q    <= 4'b0000;
        end else begin
            phase_q     <= phase_d;
            cur_road_q  <= cur_road_d;
            rr_ptr_q    <= rr_ptr_d;
            timer_q     <= timer_d;
            jam_grant_q <= jam_grant_d;
            ack_q       <= ack_d;
            green_q     <= green_d;
            yellow_q    <= yellow_d;
        end
    end

    assign preempt_ack = ack_q;
    assign green       = green_q;
    assign yellow      = yellow_q;
    assign cur_road    = cur_road_q;
    assign phase       = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_intersection_phase_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_intersection_phase_scheduler: directed stimulus with a segment         |
// | scoreboard on the lamp/phase outputs.               Revision: 1.0         |
// +--------------------------------------------------------------------------+
module tb_intersection_phase_scheduler;

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_green  = 2'd1;
    localparam logic [1:0] c_yellow = 2'd2;
    localparam logic [1:0] c_allred = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] jam = 4'b0000;
    logic       preempt_valid = 1'b0;
    logic [1:0] preempt_road = 2'd0;
    logic       preempt_ack;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [1:0] cur_road;
    logic [1:0] phase;

    intersection_phase_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .jam          (jam),
        .preempt_valid(preempt_valid),
        .preempt_road (preempt_road),
        .preempt_ack  (preempt_ack),
        .green        (green),
        .yellow       (yellow),
        .cur_road     (cur_road),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    // A segment is a maximal run of cycles with identical outputs.
    typedef struct packed {
        logic [1:0]  ph;
        logic [3:0]  g;
        logic [3:0]  y;
        logic [1:0]  rd;
        logic        ack;
        logic [15:0] len;
    } seg_t;

    seg_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   seg_no = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input logic [1:0] ph, input logic [1:0] rd, input logic ack, input int len);
        seg_t s;
        s.ph  = ph;
        s.rd  = rd;
        s.ack = ack;
        s.g   = (ph == c_green)  ? (4'b0001 << rd) : 4'b0000;
        s.y   = (ph == c_yellow) ? (4'b0001 << rd) : 4'b0000;
        s.len = 16'(len);
        exp_q.push_back(s);
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: closes a segment whenever the output tuple changes.
    seg_t cur_s, prev_s, exp_s;
    bit   started = 1'b0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            cur_s = '{ph: phase, g: green, y: yellow, rd: cur_road, ack: preempt_ack, len: 16'd1};
            n_cmp++;
            if (((green | yellow) & ((green | yellow) - 4'd1)) != 4'd0 || $isunknown(green | yellow)) begin
                n_err++;
                $display("FAIL lamp_onehot cyc=%0d: got green=%b yellow=%b, expected at most one lamp bit",
                         cyc, green, yellow);
            end
            if (!started) begin
                started = 1'b1;
                prev_s  = cur_s;
            end else if (cur_s[28:16] !== prev_s[28:16]) begin
                seg_no++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL seg%0d unexpected: got ph=%0d g=%b y=%b road=%0d ack=%b len=%0d, expected none",
                             seg_no, prev_s.ph, prev_s.g, prev_s.y, prev_s.rd, prev_s.ack, prev_s.len);
                end else begin
                    exp_s = exp_q.pop_front();
                    if (prev_s !== exp_s) begin
                        n_err++;
                        $display("FAIL seg%0d: got ph=%0d g=%b y=%b road=%0d ack=%b len=%0d, expected ph=%0d g=%b y=%b road=%0d ack=%b len=%0d",
                                 seg_no, prev_s.ph, prev_s.g, prev_s.y, prev_s.rd, prev_s.ack, prev_s.len,
                                 exp_s.ph, exp_s.g, exp_s.y, exp_s.rd, exp_s.ack, exp_s.len);
                    end
                end
                prev_s = cur_s;
            end else begin
                prev_s.len = prev_s.len + 16'd1;
            end
        end
    end

    initial begin
        // Reset idle, then single road with one extension.
        push(c_idle,   2'd0, 1'b0, 3);
        push(c_green,  2'd0, 1'b0, 32);
        push(c_yellow, 2'd0, 1'b0, 4);
        push(c_allred, 2'd0, 1'b0, 2);
        push(c_idle,   2'd0, 1'b0, 4);
        // Two roads alternating.
        push(c_green,  2'd0, 1'b0, 16);
        push(c_yellow, 2'd0, 1'b0, 4);
        push(c_allred, 2'd0, 1'b0, 2);
        push(c_green,  2'd1, 1'b0, 16);
        push(c_yellow, 2'd1, 1'b0, 4);
        push(c_allred, 2'd1, 1'b0, 2);
        push(c_green,  2'd0, 1'b0, 16);
        push(c_yellow, 2'd0, 1'b0, 4);
        push(c_allred, 2'd0, 1'b0, 2);
        push(c_idle,   2'd0, 1'b0, 6);
        // Jammed road first, then round-robin; requests drop during road 1 green.
        push(c_green,  2'd2, 1'b0, 32);
        push(c_yellow, 2'd2, 1'b0, 4);
        push(c_allred, 2'd2, 1'b0, 2);
        push(c_green,  2'd3, 1'b0, 16);
        push(c_yellow, 2'd3, 1'b0, 4);
        push(c_allred, 2'd3, 1'b0, 2);
        push(c_green,  2'd0, 1'b0, 16);
        push(c_yellow, 2'd0, 1'b0, 4);
        push(c_allred, 2'd0, 1'b0, 2);
        push(c_green,  2'd1, 1'b0, 16);
        push(c_yellow, 2'd1, 1'b0, 4);
        push(c_allred, 2'd1, 1'b0, 2);
        push(c_idle,   2'd1, 1'b0, 4);
        push(c_idle,   2'd0, 1'b0, 2);
        // Preempt truncates road 0 green.
        push(c_green,  2'd0, 1'b0, 4);
        push(c_yellow, 2'd0, 1'b0, 4);
        push(c_allred, 2'd0, 1'b0, 2);
        push(c_green,  2'd3, 1'b1, 1);
        push(c_green,  2'd3, 1'b0, 15);
        // Reset during yellow, then road 3 from the reset pointer.
        push(c_yellow, 2'd3, 1'b0, 2);
        push(c_idle,   2'd0, 1'b0, 2);
        push(c_green,  2'd3, 1'b0, 16);
        push(c_yellow, 2'd3, 1'b0, 4);
        push(c_allred, 2'd3, 1'b0, 2);
        push(c_idle,   2'd3, 1'b0, 4);

        at(3);   rst = 1'b0; req = 4'b0001;
        at(23);  req = 4'b0000;
        at(43);  rst = 1'b1;
        at(45);  rst = 1'b0; req = 4'b0011;
        at(100); req = 4'b0000;
        at(115); rst = 1'b1;
        at(117); rst = 1'b0; req = 4'b1111; jam = 4'b0100;
        at(118); jam = 4'b0000;
        at(205); req = 4'b0000;
        at(225); rst = 1'b1;
        at(227); rst = 1'b0; req = 4'b0001;
        at(231); preempt_valid = 1'b1; preempt_road = 2'd3;
        at(238); preempt_valid = 1'b0;
        at(255); rst = 1'b1;
        at(257); rst = 1'b0; req = 4'b1000;
        at(260); req = 4'b0000;
        at(283); rst = 1'b1;
        at(290);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL seg_drain: got %0d expected segments never observed, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
